// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - argmax over a snapshot of packed unsigned results, one element per enabled cycle
// Optional feature: ARGMAX_MARGIN_EN adds a winner-minus-second-max margin output.
module argmax_classifier #(
    parameter int n                      = 8,
    parameter int number_of_output       = 10,
    parameter int clog2_number_of_output = 4
) (
    input  logic                              clk,
    input  logic                              clk_en,
    input  logic                              rst,
    input  logic                              start,
    input  logic [number_of_output*n-1:0]     results,
    output logic [clog2_number_of_output-1:0] class_idx,
    output logic [n-1:0]                      max_value,
    output logic                              busy,
    output logic                              ready
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [n-1:0]                      margin
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;
    localparam logic [clog2_number_of_output-1:0] LAST =
        clog2_number_of_output'(number_of_output - 1);

    logic [0:0]                        state;
    logic [number_of_output*n-1:0]     snap;
    logic [clog2_number_of_output-1:0] cnt;
    logic [clog2_number_of_output-1:0] run_idx;
    logic [n-1:0]                      run_max;
    logic [n-1:0]                      elem;
    logic [n-1:0]                      next_max;
    logic [clog2_number_of_output-1:0] next_idx;
    logic                              take;

    always_comb begin
        elem = '0;
        for (int i = 0; i < number_of_output; i++) begin
            if (cnt == clog2_number_of_output'(i)) begin
                elem = snap[i*n +: n];
            end
        end
        // strict compare keeps the lower index on ties
        take     = elem > run_max;
        next_max = take ? elem : run_max;
        next_idx = take ? cnt : run_idx;
    end

`ifdef ARGMAX_MARGIN_EN
    logic [n-1:0] run_sec;
    logic [n-1:0] next_sec;

    // a replaced maximum becomes the runner-up
    always_comb begin
        next_sec = run_sec;
        if (take) begin
            next_sec = run_max;
        end else if (elem > run_sec) begin
            next_sec = elem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_sec <= '0;
            margin  <= '0;
        end else if (clk_en) begin
            if (state == IDLE) begin
                if (start) begin
                    run_sec <= '0;
                end
            end else begin
                run_sec <= next_sec;
                if (cnt == LAST) begin
                    margin <= next_max - next_sec;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snap      <= '0;
            cnt       <= '0;
            run_idx   <= '0;
            run_max   <= '0;
            class_idx <= '0;
            max_value <= '0;
            busy      <= 1'b0;
            ready     <= 1'b0;
        end else if (clk_en) begin
            ready <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    snap    <= results;
                    run_max <= results[n-1:0];
                    run_idx <= '0;
                    cnt     <= clog2_number_of_output'(1);
                    busy    <= 1'b1;
                    state   <= SCAN;
                end
            end else begin
                run_max <= next_max;
                run_idx <= next_idx;
                if (cnt == LAST) begin
                    class_idx <= next_idx;
                    max_value <= next_max;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - scoreboard bench for argmax_classifier with a behavioural argmax model
module tb_argmax_classifier;

    localparam int N  = 8;
    localparam int K  = 10;
    localparam int CW = 4;
    localparam int TW = N * K;

    logic          clk = 1'b0;
    logic          clk_en;
    logic          rst;
    logic          start;
    logic [TW-1:0] results;
    logic [CW-1:0] class_idx;
    logic [N-1:0]  max_value;
    logic          busy;
    logic          ready;
`ifdef ARGMAX_MARGIN_EN
    logic [N-1:0]  margin;
`endif

    typedef struct packed {
        logic [CW-1:0] idx;
        logic [N-1:0]  val;
        logic [N-1:0]  mg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_ready = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    argmax_classifier #(
        .n                      (N),
        .number_of_output       (K),
        .clog2_number_of_output (CW)
    ) dut (
        .clk       (clk),
        .clk_en    (clk_en),
        .rst       (rst),
        .start     (start),
        .results   (results),
        .class_idx (class_idx),
        .max_value (max_value),
        .busy      (busy),
`ifdef ARGMAX_MARGIN_EN
        .margin    (margin),
`endif
        .ready     (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // winner = first index holding the maximum; margin = max minus best of the rest
    function automatic exp_t model(input logic [TW-1:0] v);
        int   a[K];
        int   best;
        int   sec;
        exp_t e;
        for (int i = 0; i < K; i++) a[i] = int'(v[i*N +: N]);
        best = 0;
        for (int i = 1; i < K; i++) if (a[i] > a[best]) best = i;
        sec = 0;
        for (int i = 0; i < K; i++) if (i != best && a[i] > sec) sec = a[i];
        e.idx = CW'(best);
        e.val = N'(a[best]);
        e.mg  = N'(a[best] - sec);
        return e;
    endfunction

    function automatic logic [TW-1:0] pack(input int a[K]);
        logic [TW-1:0] r;
        for (int i = 0; i < K; i++) r[i*N +: N] = N'(a[i]);
        return r;
    endfunction

    function automatic logic [TW-1:0] rand_vec(input int hi);
        int a[K];
        for (int i = 0; i < K; i++) a[i] = int'($urandom_range(0, hi));
        return pack(a);
    endfunction

    task automatic launch(input logic [TW-1:0] v, input exp_t e);
        sb.push_back(e);
        results = v;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_ready(output int edges);
        edges = 0;
        while (ready !== 1'b1 && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1 && prev_ready !== 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("class_idx", class_idx, mon_e.idx);
                check("max_value", max_value, mon_e.val);
`ifdef ARGMAX_MARGIN_EN
                check("margin", margin, mon_e.mg);
`endif
            end
        end
        prev_ready <= ready;
    end

    initial begin
        int            a[K];
        int            edges;
        logic [TW-1:0] v;
        exp_t          e;

        rst = 1'b1; clk_en = 1'b1; start = 1'b0; results = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_class_idx", class_idx, 0);
        check("rst_max_value", max_value, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        a = '{3, 9, 1, 127, 0, 5, 5, 2, 8, 4};
        e = '{idx: 4'd3, val: 8'd127, mg: 8'd118};
        launch(pack(a), e);
        check("busy_during_scan", busy, 1);
        wait_ready(edges);
        check("latency_basic", edges + 1, 10);
        @(posedge clk); #1;
        check("ready_one_cycle", ready, 0);

        a = '{0, 0, 40, 0, 0, 0, 0, 40, 0, 0};
        e = '{idx: 4'd2, val: 8'd40, mg: 8'd0};
        launch(pack(a), e);
        wait_ready(edges);
        check("latency_tie", edges + 1, 10);
        @(posedge clk); #1;

        a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e = '{idx: 4'd0, val: 8'd0, mg: 8'd0};
        launch(pack(a), e);
        wait_ready(edges);
        check("latency_zero", edges + 1, 10);
        @(posedge clk); #1;

        v = rand_vec(255);
        launch(v, model(v));
        repeat (3) @(posedge clk);
        #1;
        results = rand_vec(255);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_midscan_start", busy, 1);
        wait_ready(edges);
        check("latency_stress", edges + 5, 10);
        repeat (13) @(posedge clk);
        #1;
        check("no_restart_busy", busy, 0);

        a = '{1, 1, 1, 1, 1, 1, 77, 1, 1, 1};
        v = pack(a);
        launch(v, model(v));
        wait_ready(edges);
        @(posedge clk); #1;
        launch(v, model(v));
        repeat (4) @(posedge clk);
        #1;
        void'(sb.pop_back());
        rst = 1'b1; clk_en = 1'b0;
        @(posedge clk); #1;
        check("midrst_class_idx", class_idx, 0);
        check("midrst_max_value", max_value, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 0);
`ifdef ARGMAX_MARGIN_EN
        check("midrst_margin", margin, 0);
`endif
        rst = 1'b0; clk_en = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_idle", busy, 0);

        v = rand_vec(255);
        launch(v, model(v));
        repeat (3) @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_hold_clk_en", busy, 1);
        clk_en = 1'b1;
        wait_ready(edges);
        check("latency_clk_en", edges + 7, 13);
        clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ready_held_disabled", ready, 1);
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("ready_cleared_enabled", ready, 0);

        v = rand_vec(200);
        launch(v, model(v));
        wait_ready(edges);
        for (int i = 0; i < K; i++) a[i] = int'($urandom_range(0, 254));
        a[9] = 255;
        v = pack(a);
        launch(v, model(v));
        wait_ready(edges);
        check("b2b_latency", edges + 1, 10);
        check("b2b_class_idx", class_idx, 9);
        @(posedge clk); #1;

        for (int t = 0; t < 20; t++) begin
            v = rand_vec((t % 2 == 0) ? 3 : 255);
            launch(v, model(v));
            wait_ready(edges);
            check("latency_rand", edges + 1, 10);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
